// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, oversampling ratio,
// idle line level and status register bit positions (common to RX and TX).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int unsigned OVERSAMPLE = 16;
  localparam logic        IDLE_LEVEL = 1'b1;

  localparam int unsigned ST_ERR_WR = 0;
  localparam int unsigned ST_FULL   = 1;
  localparam int unsigned ST_EMPTY  = 2;
  localparam int unsigned ST_BUSY   = 7;

endpackage

// File: rtl/uart_fifo.sv
// Synchronous FIFO with occupancy count and sticky write-overflow flag.
// Full is evaluated before a same-cycle read, so a write into a full FIFO
// is always rejected even if a word leaves in that cycle.
module uart_fifo #(
  parameter int DATA_SIZE = 8,
  parameter int SIZE_FIFO = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write,
  input  logic                 read,
  input  logic [DATA_SIZE-1:0] data_in,
  output logic [DATA_SIZE-1:0] data_out,
  output logic                 full,
  output logic                 empty,
  output logic                 error_write_data
);

  localparam int unsigned PTR_W = (SIZE_FIFO > 1) ? $clog2(SIZE_FIFO) : 1;

  logic [DATA_SIZE-1:0] mem [SIZE_FIFO];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [PTR_W:0]       count;
  logic                 do_write;
  logic                 do_read;

  assign full     = (count == (PTR_W+1)'(SIZE_FIFO));
  assign empty    = (count == '0);
  assign do_write = write && !full;
  assign do_read  = read && !empty;
  assign data_out = mem[rd_ptr];

  // Storage array: written only on accepted writes, no reset needed
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // Pointers, occupancy and overflow flag; pointers wrap modulo SIZE_FIFO
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      count            <= '0;
      error_write_data <= 1'b0;
    end else begin
      if (do_write) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_read) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_write && !do_read) begin
        count <= count + 1'b1;
      end else if (do_read && !do_write) begin
        count <= count - 1'b1;
      end
      if (write) begin
        error_write_data <= full;
      end
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit half: FIFO-buffered bytes serialised as start, DATA_SIZE
// data bits LSB first, optional even parity, one stop bit; 16 clk per bit.
// Define UART_TX_PARITY_EN to include the parity bit in every frame.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int DATA_SIZE      = 8,
  parameter int SIZE_FIFO      = 8,
  parameter int BIT_COUNT_SIZE = $clog2(DATA_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 write_data,
  input  logic [DATA_SIZE-1:0] bus_data,
  output logic                 serial_data_out,
  output logic [7:0]           status_register
);

  tx_state_t                 state;
  logic [3:0]                sample_count;
  logic [BIT_COUNT_SIZE:0]   bit_count;
  logic [DATA_SIZE-1:0]      tx_shift_reg;
  logic                      tx_busy;
  logic                      bit_done;
  logic                      pop;
  logic [DATA_SIZE-1:0]      fifo_data;
  logic                      fifo_full;
  logic                      fifo_empty;
  logic                      error_write_data;
`ifdef UART_TX_PARITY_EN
  logic                      tx_parity;
`endif

  assign bit_done = (sample_count == 4'(OVERSAMPLE - 1));

  // The FSM pops whenever it is about to load a new word
  assign pop = !fifo_empty &&
               ((state == IDLE) || ((state == STOP) && bit_done));

  uart_fifo #(
    .DATA_SIZE (DATA_SIZE),
    .SIZE_FIFO (SIZE_FIFO)
  ) u_fifo (
    .clk              (clk),
    .reset            (reset),
    .write            (write_data),
    .read             (pop),
    .data_in          (bus_data),
    .data_out         (fifo_data),
    .full             (fifo_full),
    .empty            (fifo_empty),
    .error_write_data (error_write_data)
  );

  // Status word in the layout shared with the receiver
  always_comb begin
    status_register           = '0;
    status_register[ST_BUSY]  = tx_busy;
    status_register[ST_EMPTY] = fifo_empty;
    status_register[ST_FULL]  = fifo_full;
    status_register[ST_ERR_WR] = error_write_data;
  end

  // Frame sequencer; the line level is registered alongside each state change
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      sample_count    <= '0;
      bit_count       <= '0;
      tx_shift_reg    <= '0;
      tx_busy         <= 1'b0;
      serial_data_out <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      tx_parity       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          sample_count <= '0;
          if (!fifo_empty) begin
            tx_shift_reg    <= fifo_data;
            bit_count       <= '0;
            state           <= START;
            tx_busy         <= 1'b1;
            serial_data_out <= ~IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            tx_parity       <= ^fifo_data;
`endif
          end else begin
            tx_busy         <= 1'b0;
            serial_data_out <= IDLE_LEVEL;
          end
        end

        START: begin
          sample_count <= sample_count + 1'b1;
          if (bit_done) begin
            state           <= DATA;
            serial_data_out <= tx_shift_reg[0];
          end
        end

        // The next bit is presented from tx_shift_reg[1] in the same edge
        // that shifts, so the line never shows a stale bit for a cycle.
        DATA: begin
          sample_count <= sample_count + 1'b1;
          if (bit_done) begin
            if (bit_count == (BIT_COUNT_SIZE+1)'(DATA_SIZE - 1)) begin
`ifdef UART_TX_PARITY_EN
              state           <= PARITY;
              serial_data_out <= tx_parity;
`else
              state           <= STOP;
              serial_data_out <= IDLE_LEVEL;
`endif
            end else begin
              tx_shift_reg    <= tx_shift_reg >> 1;
              serial_data_out <= tx_shift_reg[1];
              bit_count       <= bit_count + 1'b1;
            end
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          sample_count <= sample_count + 1'b1;
          if (bit_done) begin
            state           <= STOP;
            serial_data_out <= IDLE_LEVEL;
          end
        end
`endif

        STOP: begin
          sample_count <= sample_count + 1'b1;
          if (bit_done) begin
            if (!fifo_empty) begin
              tx_shift_reg    <= fifo_data;
              bit_count       <= '0;
              state           <= START;
              serial_data_out <= ~IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
              tx_parity       <= ^fifo_data;
`endif
            end else begin
              state           <= IDLE;
              tx_busy         <= 1'b0;
              serial_data_out <= IDLE_LEVEL;
            end
          end
        end

        default: begin
          state           <= IDLE;
          tx_busy         <= 1'b0;
          serial_data_out <= IDLE_LEVEL;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_transmitter.md
# uart_transmitter

Transmit half of the UART. It accepts parallel bytes from the bus into a small FIFO and serializes each byte onto `serial_data_out` as an asynchronous frame: start bit, 8 data bits LSB first, optional parity, one stop bit. Every bit lasts 16 `clk` cycles, matching the 16x oversampling clock the receiver uses. It exposes an 8-bit status register with the same bit layout as the receive side, so software polls both halves identically.

## Interface
Parameters:
- `DATA_SIZE`, 8: data bits per frame.
- `SIZE_FIFO`, 8: transmit FIFO depth in words; power of two.
- `BIT_COUNT_SIZE`, `$clog2(DATA_SIZE)`: the bit counter is `BIT_COUNT_SIZE+1` bits wide.

Ports:
- `clk` in 1: single clock, 16x baud rate.
- `reset` in 1: asynchronous, active-high reset.
- `write_data` in 1: one-cycle strobe that pushes `bus_data` into the FIFO.
- `bus_data` in `DATA_SIZE`: byte to transmit.
- `serial_data_out` out 1: registered serial line; idles high.
- `status_register` out 8: `{tx_busy, 0, 0, 0, 0, empty, full, error_write_data}`.

## Operation
FSM states, held in the `tx_state_t` enum:
- **IDLE**: line high. If the FIFO is not empty, pop one word, load it into `tx_shift_reg`, clear the counters, and go to START.
- **START**: line low for 16 cycles, then go to DATA.
- **DATA**: line = `tx_shift_reg[0]`. Shift right every 16 cycles; after `DATA_SIZE` bits go to PARITY (macro defined) or STOP.
- **PARITY**: line = even parity (XOR) of the loaded byte for 16 cycles, then go to STOP.
- **STOP**: line high for 16 cycles. If the FIFO is not empty, pop, reload, and go straight to START with no idle gap; otherwise go to IDLE.

Counters:
- `sample_count` is 4 bits, counts 0–15 and wraps. Reaching 15 is the bit-done condition.
- `bit_count` clears on load and increments on every bit-done in DATA. The DATA-to-next-state transition happens when `bit_count == DATA_SIZE-1` and the bit is done.

Status and write rules:
- `tx_busy` = 1 in every state except IDLE.
- `write_data` while `full`: the word is dropped and `error_write_data` sets. The flag is sticky until the next accepted write, which clears it in the same cycle.
- `write_data` and pop in the same cycle with the FIFO full: the write is still rejected. Full is evaluated before the pop.
- `write_data` and pop in the same cycle with the FIFO neither full nor empty: both happen and the occupancy is unchanged.
- FIFO pointers wrap modulo `SIZE_FIFO`.

## Timing
Reset values:
- `serial_data_out` = 1.
- `status_register` = 8'b0000_0100 (empty only).
- FSM in IDLE, counters 0, shift register 0, FIFO emptied.

Latency and frame length:
- `write_data` sampled at edge N into an empty, idle block: `empty` falls after edge N.
- The FSM pops at edge N+1, so the start bit drives `serial_data_out` low from edge N+1.
- The start bit lasts 16 cycles. Data bit k occupies edges N+1+16(k+1) through N+16(k+2).
- Frame length is 160 cycles, or 176 with parity. `tx_busy` falls at the end of the stop bit when the FIFO is empty.
- Back-to-back frames: the next start bit begins on the cycle immediately after the 16th stop cycle.

Reset mid-frame aborts the frame immediately: line high, FIFO contents lost, no partial frame completes.

`serial_data_out` is driven from a flop, so it is glitch-free.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state exists and frames are 11 bits (start, 8 data, even parity, stop).
- Not defined: PARITY is compiled out and frames are 10 bits. No other behaviour changes.

## Structure
- Shared package `uart_pkg` holds:
  - `tx_state_t` (IDLE, START, DATA, PARITY, STOP).
  - `OVERSAMPLE = 16`.
  - `IDLE_LEVEL = 1'b1`.
  - The status bit index constants (`ST_ERR_WR = 0`, `ST_FULL = 1`, `ST_EMPTY = 2`, `ST_BUSY = 7`), shared with the receiver.
- One sub-module: the existing `uart_fifo`, parameterized with `DATA_SIZE` and `SIZE_FIFO`. Its `write` is `write_data`, its `read` is the FSM pop, and its `data_out` feeds `tx_shift_reg`.
- The FSM, counters and shift register stay in `uart_transmitter`.

## Test plan
- **Single byte**: write 8'hA5 into an idle block. Line falls 2 clk after the strobe. Sampling mid-bit reads 0,1,0,1,0,0,1,0,1, then 1 (stop). `tx_busy` is 1 for 160 cycles, then 0.
- **Parity**: with `UART_TX_PARITY_EN`, bytes 8'h07 and 8'h03 give parity bits 1 and 0 respectively. Frame length is 176 cycles.
- **Back-to-back**: write 8'h00 then 8'hFF on consecutive cycles. The second start bit follows the first stop bit with zero idle cycles. `empty` returns to 1 when the second frame's load pops the FIFO.
- **Overflow**: 9 writes, with the block already busy on a prior frame. `full` = 1 after the 8th, and the 9th sets `error_write_data`. The dropped word is never transmitted. A subsequent accepted write clears the flag.
- **Reset mid-frame**: assert `reset` during data bit 3. The line goes to 1 asynchronously, status reads 8'h04, and a new write afterwards transmits correctly.
